// File: rtl/cnte_gen_if.sv
// rtl/cnte_gen_if.sv - control and status bundle for the cnte_gen enabled counter
interface cnte_gen_if #(
  parameter int WIDTH = 3
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             cnten;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             at_max;
  logic             wrap;

  modport master (
    output clear, load, load_val, cnten, up,
    input  count, zero, at_max, wrap
  );

  modport slave (
    input  clear, load, load_val, cnten, up,
    output count, zero, at_max, wrap
  );
endinterface

// File: rtl/cnte_gen.sv
// rtl/cnte_gen.sv - parametrised up/down enabled counter with modulus, load, clear and wrap/saturate
module cnte_gen #(
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] MAXVAL   = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input logic      clk,
  input logic      reset,
  cnte_gen_if.slave bus
);
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  // Limits are compared explicitly so a modulus below 2**WIDTH-1 never relies on overflow.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = (bus.load_val > MAXVAL) ? MAXVAL : bus.load_val;
    end else if (bus.cnten) begin
      if (bus.up) begin
        if (count_q == MAXVAL) begin
          wrap_d  = 1'b1;
          count_d = SATURATE ? count_q : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          wrap_d  = 1'b1;
          count_d = SATURATE ? count_q : MAXVAL;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.zero   = (count_q == '0);
  assign bus.at_max = (count_q == MAXVAL);
  assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_cnte_gen.sv
// tb/tb_cnte_gen.sv - directed self-checking bench for cnte_gen across several parameter sets
module tb_cnte_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cnte_gen_if #(.WIDTH(3)) b0 ();
  cnte_gen_if #(.WIDTH(4)) b1 ();
  cnte_gen_if #(.WIDTH(3)) b2 ();
  cnte_gen_if #(.WIDTH(2)) b3 ();

  cnte_gen #(.WIDTH(3)) d0 (.clk(clk), .reset(reset), .bus(b0.slave));
  cnte_gen #(.WIDTH(4), .MAXVAL(4'd9)) d1 (.clk(clk), .reset(reset), .bus(b1.slave));
  cnte_gen #(.WIDTH(3), .SATURATE(1'b1)) d2 (.clk(clk), .reset(reset), .bus(b2.slave));
  cnte_gen #(.WIDTH(2), .MAXVAL(2'd1)) d3 (.clk(clk), .reset(reset), .bus(b3.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b0.clear = 0; b0.load = 0; b0.load_val = '0; b0.cnten = 0; b0.up = 1;
    b1.clear = 0; b1.load = 0; b1.load_val = '0; b1.cnten = 0; b1.up = 1;
    b2.clear = 0; b2.load = 0; b2.load_val = '0; b2.cnten = 0; b2.up = 1;
    b3.clear = 0; b3.load = 0; b3.load_val = '0; b3.cnten = 0; b3.up = 1;
  endtask

  task automatic test_reset();
    int exp_c[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    logic [2:0] e;
    idle_all();
    reset = 1; b0.cnten = 1; b0.load = 1; b0.load_val = 3'd5; b0.up = 1;
    tick();
    total++; if (b0.count !== 3'd0) begin $display("FAIL reset_count got=%0d exp=0", b0.count); bad++; end
    total++; if (b0.zero !== 1'b1) begin $display("FAIL reset_zero got=%b exp=1", b0.zero); bad++; end
    total++; if (b0.at_max !== 1'b0) begin $display("FAIL reset_at_max got=%b exp=0", b0.at_max); bad++; end
    total++; if (b0.wrap !== 1'b0) begin $display("FAIL reset_wrap got=%b exp=0", b0.wrap); bad++; end
    reset = 0; b0.load = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      e = 3'(exp_c[i]);
      total++; if (b0.count !== e) begin $display("FAIL up_count[%0d] got=%0d exp=%0d", i, b0.count, e); bad++; end
      total++; if (b0.wrap !== (i == 7)) begin $display("FAIL up_wrap[%0d] got=%b exp=%b", i, b0.wrap, (i == 7)); bad++; end
    end
    b0.cnten = 0;
  endtask

  task automatic test_modulus_down();
    int exp_c[4] = '{1, 0, 9, 8};
    logic [3:0] e;
    b1.load = 1; b1.load_val = 4'd2;
    tick();
    total++; if (b1.count !== 4'd2) begin $display("FAIL mod_load got=%0d exp=2", b1.count); bad++; end
    b1.load = 0; b1.cnten = 1; b1.up = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = 4'(exp_c[i]);
      total++; if (b1.count !== e) begin $display("FAIL down_count[%0d] got=%0d exp=%0d", i, b1.count, e); bad++; end
      total++; if (b1.wrap !== (i == 2)) begin $display("FAIL down_wrap[%0d] got=%b exp=%b", i, b1.wrap, (i == 2)); bad++; end
      total++; if (b1.at_max !== (e == 4'd9)) begin $display("FAIL down_at_max[%0d] got=%b exp=%b", i, b1.at_max, (e == 4'd9)); bad++; end
    end
    b1.cnten = 0; b1.up = 1;
  endtask

  task automatic test_saturate();
    b2.load = 1; b2.load_val = 3'd6;
    tick();
    total++; if (b2.count !== 3'd6) begin $display("FAIL sat_load got=%0d exp=6", b2.count); bad++; end
    b2.load = 0; b2.cnten = 1; b2.up = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (b2.count !== 3'd7) begin $display("FAIL sat_count[%0d] got=%0d exp=7", i, b2.count); bad++; end
      total++; if (b2.wrap !== (i != 0)) begin $display("FAIL sat_wrap[%0d] got=%b exp=%b", i, b2.wrap, (i != 0)); bad++; end
      total++; if (b2.at_max !== 1'b1) begin $display("FAIL sat_at_max[%0d] got=%b exp=1", i, b2.at_max); bad++; end
    end
    b2.up = 0;
    tick();
    total++; if (b2.count !== 3'd6) begin $display("FAIL sat_down got=%0d exp=6", b2.count); bad++; end
    total++; if (b2.wrap !== 1'b0) begin $display("FAIL sat_down_wrap got=%b exp=0", b2.wrap); bad++; end
    b2.load = 1; b2.load_val = 3'd0; b2.up = 0;
    tick();
    b2.load = 0;
    tick();
    total++; if (b2.count !== 3'd0) begin $display("FAIL sat_floor got=%0d exp=0", b2.count); bad++; end
    total++; if (b2.wrap !== 1'b1) begin $display("FAIL sat_floor_wrap got=%b exp=1", b2.wrap); bad++; end
    b2.cnten = 0;
  endtask

  task automatic test_load_clamp();
    b1.load = 1; b1.load_val = 4'd14;
    tick();
    total++; if (b1.count !== 4'd9) begin $display("FAIL clamp_count got=%0d exp=9", b1.count); bad++; end
    total++; if (b1.at_max !== 1'b1) begin $display("FAIL clamp_at_max got=%b exp=1", b1.at_max); bad++; end
    b1.cnten = 1; b1.up = 1; b1.load_val = 4'd3;
    tick();
    total++; if (b1.count !== 4'd3) begin $display("FAIL load_over_cnten got=%0d exp=3", b1.count); bad++; end
    total++; if (b1.wrap !== 1'b0) begin $display("FAIL load_over_cnten_wrap got=%b exp=0", b1.wrap); bad++; end
    b1.cnten = 0; b1.clear = 1; b1.load_val = 4'd7;
    tick();
    total++; if (b1.count !== 4'd0) begin $display("FAIL clear_over_load got=%0d exp=0", b1.count); bad++; end
    total++; if (b1.zero !== 1'b1) begin $display("FAIL clear_zero got=%b exp=1", b1.zero); bad++; end
    b1.clear = 0; b1.load = 0;
  endtask

  task automatic test_hold_dir();
    int  exp_c[5] = '{5, 5, 4, 4, 5};
    bit  en[5]    = '{1, 0, 1, 0, 1};
    bit  dir[5]   = '{1, 0, 0, 1, 1};
    logic [2:0] e;
    b0.load = 1; b0.load_val = 3'd4;
    tick();
    b0.load = 0;
    for (int i = 0; i < 5; i++) begin
      b0.cnten = en[i]; b0.up = dir[i];
      tick();
      e = 3'(exp_c[i]);
      total++; if (b0.count !== e) begin $display("FAIL hold_count[%0d] got=%0d exp=%0d", i, b0.count, e); bad++; end
      total++; if (b0.wrap !== 1'b0) begin $display("FAIL hold_wrap[%0d] got=%b exp=0", i, b0.wrap); bad++; end
    end
    b0.cnten = 0;
  endtask

  task automatic test_reset_mid();
    b0.load = 1; b0.load_val = 3'd6;
    tick();
    total++; if (b0.count !== 3'd6) begin $display("FAIL mid_preload got=%0d exp=6", b0.count); bad++; end
    b0.load = 0; b0.cnten = 1; b0.up = 1; reset = 1;
    tick();
    total++; if (b0.count !== 3'd0) begin $display("FAIL mid_reset_count got=%0d exp=0", b0.count); bad++; end
    total++; if (b0.wrap !== 1'b0) begin $display("FAIL mid_reset_wrap got=%b exp=0", b0.wrap); bad++; end
    reset = 0;
    tick();
    total++; if (b0.count !== 3'd1) begin $display("FAIL mid_after_count got=%0d exp=1", b0.count); bad++; end
    b0.cnten = 0;
  endtask

  task automatic test_back_to_back();
    int exp_c[4] = '{0, 1, 0, 1};
    bit dir[4]   = '{1, 0, 1, 1};
    bit exp_w[4] = '{1, 1, 1, 0};
    logic [1:0] e;
    b3.load = 1; b3.load_val = 2'd3;
    tick();
    total++; if (b3.count !== 2'd1) begin $display("FAIL b2b_clamp got=%0d exp=1", b3.count); bad++; end
    b3.load = 0; b3.cnten = 1;
    for (int i = 0; i < 4; i++) begin
      b3.up = dir[i];
      tick();
      e = 2'(exp_c[i]);
      total++; if (b3.count !== e) begin $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, b3.count, e); bad++; end
      total++; if (b3.wrap !== exp_w[i]) begin $display("FAIL b2b_wrap[%0d] got=%b exp=%b", i, b3.wrap, exp_w[i]); bad++; end
    end
    b3.cnten = 0;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_modulus_down();
    test_saturate();
    test_load_clamp();
    test_hold_dir();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
